// File: rtl/lcd_bus_receiver.sv
// Responder side of the character-LCD write bus: synchronizes E/RS/RW/DATA, decodes
// HD44780-style instructions and keeps a 32-byte DDRAM shadow with a registered read port.
module lcd_bus_receiver #(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned CLEAR_CYCLES = 32
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       E,
    input  logic       RS,
    input  logic       RW,
    input  logic [7:0] DATA,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_char,
    output logic [4:0] cursor,
    output logic       id_inc,
    output logic       disp_on,
    output logic       busy,
    output logic       cmd_valid,
    output logic [7:0] cmd_code,
    output logic       overrun,
    output logic       addr_err
);

    localparam int unsigned CNT_W = $clog2(CLEAR_CYCLES + 1);

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] e_sync, rs_sync, rw_sync;
    logic [7:0]             data_sync [SYNC_STAGES];
    logic                   e_prev;

    logic       e_s, rs_s, rw_s, strobe;
    logic [7:0] d_s;
    logic       accept, wr_data, wr_cmd;
    logic       op_clear, op_home, op_entry, op_disp, op_shift, op_setdd;
    logic [CNT_W-1:0] clr_cnt;
    logic       clr_last;

    logic [7:0] ddram [32];

    function automatic logic [4:0] step(input logic [4:0] a, input logic up);
        // 5-bit wrap gives the row0/row1 crossing and the 0x1F<->0x00 wrap directly
        return up ? a + 5'd1 : a - 5'd1;
    endfunction

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            e_sync  <= '0;
            rs_sync <= '0;
            rw_sync <= '0;
            e_prev  <= 1'b0;
            for (int unsigned i = 0; i < SYNC_STAGES; i++) data_sync[i] <= '0;
        end else begin
            e_sync       <= {e_sync[SYNC_STAGES-2:0], E};
            rs_sync      <= {rs_sync[SYNC_STAGES-2:0], RS};
            rw_sync      <= {rw_sync[SYNC_STAGES-2:0], RW};
            e_prev       <= e_sync[SYNC_STAGES-1];
            data_sync[0] <= DATA;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) data_sync[i] <= data_sync[i-1];
        end
    end

    assign e_s    = e_sync[SYNC_STAGES-1];
    assign rs_s   = rs_sync[SYNC_STAGES-1];
    assign rw_s   = rw_sync[SYNC_STAGES-1];
    assign d_s    = data_sync[SYNC_STAGES-1];
    assign strobe = e_prev & ~e_s;

    assign busy    = (state == ST_CLEAR);
    assign accept  = strobe & ~rw_s & ~busy;
    assign wr_data = accept & rs_s;
    assign wr_cmd  = accept & ~rs_s;

    always_comb begin
        op_clear = 1'b0;
        op_home  = 1'b0;
        op_entry = 1'b0;
        op_disp  = 1'b0;
        op_shift = 1'b0;
        op_setdd = 1'b0;
        if (d_s[7])                 op_setdd = 1'b1;
        else if (d_s[6] | d_s[5])   op_setdd = 1'b0;
        else if (d_s[4])            op_shift = 1'b1;
        else if (d_s[3])            op_disp  = 1'b1;
        else if (d_s[2])            op_entry = 1'b1;
        else if (d_s[1])            op_home  = 1'b1;
        else if (d_s[0])            op_clear = 1'b1;
    end

    assign clr_last = (clr_cnt == CNT_W'(CLEAR_CYCLES - 1));

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (wr_cmd && op_clear) state_next = ST_CLEAR;
            ST_CLEAR: if (clr_last)           state_next = ST_IDLE;
            default:                          state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cursor    <= '0;
            id_inc    <= 1'b1;
            disp_on   <= 1'b0;
            cmd_valid <= 1'b0;
            cmd_code  <= '0;
            overrun   <= 1'b0;
            addr_err  <= 1'b0;
            clr_cnt   <= '0;
        end else begin
            cmd_valid <= wr_cmd;
            if (strobe && !rw_s && busy) overrun <= 1'b1;
            if (busy) clr_cnt <= clr_cnt + CNT_W'(1);
            if (wr_data) cursor <= step(cursor, id_inc);
            if (wr_cmd) begin
                cmd_code <= d_s;
                if (op_clear) begin
                    cursor  <= '0;
                    id_inc  <= 1'b1;
                    clr_cnt <= '0;
                end
                if (op_home)  cursor  <= '0;
                if (op_entry) id_inc  <= d_s[1];
                if (op_disp)  disp_on <= d_s[2];
                if (op_shift && !d_s[3]) cursor <= step(cursor, d_s[2]);
                if (op_setdd) begin
                    cursor <= {d_s[6], d_s[3:0]};
                    if (d_s[5:4] != 2'b00) addr_err <= 1'b1;
                end
            end
        end
    end

    // Clear fills one cell per busy clock; strobes are dropped while busy so the ports never collide.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned k = 0; k < 32; k++) ddram[k] <= 8'h20;
        end else if (busy) begin
            if (clr_cnt < CNT_W'(32)) ddram[clr_cnt[4:0]] <= 8'h20;
        end else if (wr_data) begin
            ddram[cursor] <= d_s;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) rd_char <= '0;
        else        rd_char <= ddram[rd_addr];
    end

endmodule
